// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: memory-stage FSM encoding,
// opcode constants and instruction field positions.
package cpu_pkg;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_REQ  = 1'b1
  } ma_state_e;

  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2b;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  // Identity of a controller request; a change means a new access is wanted.
  function automatic logic [3:0] mk_tuple(input logic rd, input logic wr,
                                          input logic iord, input logic irw);
    return {rd, wr, iord, irw};
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts request cycles that went unacknowledged; tc_o fires on the cycle
// that would make the count reach TIMEOUT.
module mem_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  assign tc_o = en_i & (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multi-cycle CPU: turns level-held controller
// requests into one req/ack transaction and holds the IR and MDR.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_busy,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        OpCode,
  output logic [5:0]        Funct,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  ma_state_e         state_q;
  logic              m_req_q, m_we_q, bus_err_q, served_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q, instr_q, mdr_q;
  logic [3:0]        tuple_q;

  logic       req_now, served_eff, issue, in_req, tmo;
  logic [3:0] tuple;

  assign req_now = MemRead | MemWrite;
  assign tuple   = mk_tuple(MemRead, MemWrite, IorD, IRWrite);
  // A different tuple releases served in the same cycle, so back-to-back
  // accesses issue without an idle cycle.
  assign served_eff = served_q & req_now & (tuple == tuple_q);
  assign issue      = (state_q == MA_IDLE) & req_now & ~served_eff;
  assign in_req     = (state_q == MA_REQ);
  assign mem_busy   = issue | (in_req & ~m_ack);

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (~in_req | m_ack),
    .en_i   (in_req & ~m_ack),
    .tc_o   (tmo)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MA_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      bus_err_q <= 1'b0;
      served_q  <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      instr_q   <= '0;
      mdr_q     <= '0;
      tuple_q   <= '0;
    end else begin
      case (state_q)
        MA_IDLE: begin
          served_q <= served_eff;
          if (issue) begin
            state_q   <= MA_REQ;
            m_req_q   <= 1'b1;
            m_we_q    <= MemWrite;
            m_addr_q  <= IorD ? alu_out : pc;
            m_wdata_q <= wdata;
            tuple_q   <= tuple;
            if (MemRead & MemWrite) bus_err_q <= 1'b1;
          end
        end
        MA_REQ: begin
          if (m_ack) begin
            // tuple_q = {rd, wr, iord, irw}; a write captures nothing.
            if (!m_we_q) begin
              mdr_q <= m_rdata;
              if (tuple_q[0] & ~tuple_q[1]) instr_q <= m_rdata;
            end
            state_q  <= MA_IDLE;
            m_req_q  <= 1'b0;
            m_we_q   <= 1'b0;
            served_q <= 1'b1;
          end else if (tmo) begin
            bus_err_q <= 1'b1;
            state_q   <= MA_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            served_q  <= 1'b1;
          end
        end
        default: state_q <= MA_IDLE;
      endcase
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign bus_err = bus_err_q;
  assign instr   = instr_q;
  assign mdr     = mdr_q;
  assign OpCode  = instr_q[OP_HI:OP_LO];
  assign Funct   = instr_q[FN_HI:FN_LO];

endmodule
